// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM states and status-flag indices for alu_seq.
// Consumed by alu_seq and alu_mul_iter; the multiplier is gated by ALU_SEQ_MUL_EN.
package alu_pkg;

  localparam logic [3:0] OP_MOV = 4'b0000;
  localparam logic [3:0] OP_NOT = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_NGA = 4'b0110;
  localparam logic [3:0] OP_NGB = 4'b0111;
  localparam logic [3:0] OP_XOR = 4'b1000;
  localparam logic [3:0] OP_LSL = 4'b1001;
  localparam logic [3:0] OP_LSR = 4'b1010;
  localparam logic [3:0] OP_ASR = 4'b1011;
  localparam logic [3:0] OP_MUL = 4'b1100;
  localparam logic [3:0] OP_ADC = 4'b1101;
  localparam logic [3:0] OP_CMP = 4'b1110;
  localparam logic [3:0] OP_RSV = 4'b1111;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_e;

  // Bit positions of {N,Z,C,V} in the status word read by branch logic.
  localparam int FLAG_V = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;

endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - shift-add multiplier, one multiplier bit per cycle.
// Instantiated by alu_seq only when ALU_SEQ_MUL_EN is defined.
module alu_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] prod_o
);
  import alu_pkg::*;

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               run_q, run_d, done_q, done_d;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    done_d   = 1'b0;
    // Bit 0 is folded into the accepting edge so the product is ready after WIDTH-1 more edges.
    if (start_i) begin
      acc_d    = b_i[0] ? {{WIDTH{1'b0}}, a_i} : '0;
      mcand_d  = {{(WIDTH-1){1'b0}}, a_i, 1'b0};
      mplier_d = b_i >> 1;
      cnt_d    = CW'(1);
      run_d    = 1'b1;
    end else if (run_q) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (cnt_q == CW'(WIDTH - 1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
      done_q   <= done_d;
    end
  end

  assign done_o = done_q;
  assign prod_o = acc_q;

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered ALU with NZCV flags and start/busy/done handshake.
// Define ALU_SEQ_MUL_EN to add the iterative multiplier (opcode 1100) and the busy path.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op_alu,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             busy,
  output logic             done
);
  import alu_pkg::*;

  localparam int MSB = WIDTH - 1;

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d, done_q, done_d;

  logic [WIDTH:0]   ext;
  logic [WIDTH-1:0] res;
  logic             res_c, res_v, upd_y;
  logic [SHW-1:0]   sh;

  assign sh = b[SHW-1:0];

`ifdef ALU_SEQ_MUL_EN
  logic               mul_start, mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  assign mul_start = start && (state_q == ST_IDLE) && (op_alu == OP_MUL);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start_i (mul_start),
    .a_i     (a),
    .b_i     (b),
    .done_o  (mul_done),
    .prod_o  (mul_prod)
  );
`endif

  // Single-cycle datapath; carry and overflow come from a WIDTH+1 bit result.
  always_comb begin
    ext   = '0;
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    upd_y = 1'b1;
    case (op_alu)
      OP_MOV: res = a;
      OP_NOT: res = ~a;
      OP_ADD, OP_ADC: begin
        ext   = {1'b0, a} + {1'b0, b}
              + ((op_alu == OP_ADC) ? {{WIDTH{1'b0}}, c_q} : '0);
        res   = ext[MSB:0];
        res_c = ext[WIDTH];
        res_v = (a[MSB] == b[MSB]) && (res[MSB] != a[MSB]);
      end
      OP_SUB, OP_CMP: begin
        ext   = {1'b0, a} - {1'b0, b};
        res   = ext[MSB:0];
        res_c = ext[WIDTH];
        res_v = (a[MSB] != b[MSB]) && (res[MSB] != a[MSB]);
        upd_y = (op_alu == OP_SUB);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_NGA: begin
        ext   = {(WIDTH+1){1'b0}} - {1'b0, a};
        res   = ext[MSB:0];
        res_c = ext[WIDTH];
        res_v = a[MSB] && res[MSB];
      end
      OP_NGB: begin
        ext   = {(WIDTH+1){1'b0}} - {1'b0, b};
        res   = ext[MSB:0];
        res_c = ext[WIDTH];
        res_v = b[MSB] && res[MSB];
      end
      // Shifts carry one guard bit so the last bit shifted out lands in ext.
      OP_LSL: begin
        ext   = {1'b0, a} << sh;
        res   = ext[MSB:0];
        res_c = ext[WIDTH];
      end
      OP_LSR: begin
        ext   = {a, 1'b0} >> sh;
        res   = ext[WIDTH:1];
        res_c = ext[0];
      end
      OP_ASR: begin
        ext   = $signed({a, 1'b0}) >>> sh;
        res   = ext[WIDTH:1];
        res_c = ext[0];
      end
      default: res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    z_d     = z_q;
    n_d     = n_q;
    c_d     = c_q;
    v_d     = v_q;
    done_d  = 1'b0;
    if (state_q == ST_IDLE) begin
      if (start) begin
`ifdef ALU_SEQ_MUL_EN
        if (op_alu == OP_MUL) begin
          state_d = ST_MUL;
        end else
`endif
        begin
          if (upd_y) y_d = res;
          z_d    = (res == '0);
          n_d    = res[MSB];
          c_d    = res_c;
          v_d    = res_v;
          done_d = 1'b1;
        end
      end
    end
`ifdef ALU_SEQ_MUL_EN
    else if (mul_done) begin
      y_d     = mul_prod[MSB:0];
      z_d     = (mul_prod[MSB:0] == '0);
      n_d     = mul_prod[MSB];
      c_d     = |mul_prod[2*WIDTH-1:WIDTH];
      v_d     = |mul_prod[2*WIDTH-1:WIDTH];
      done_d  = 1'b1;
      state_d = ST_IDLE;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      y_q     <= '0;
      z_q     <= 1'b1;
      n_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      z_q     <= z_d;
      n_q     <= n_d;
      c_q     <= c_d;
      v_q     <= v_d;
      done_q  <= done_d;
    end
  end

  assign y        = y_q;
  assign zero     = z_q;
  assign negative = n_q;
  assign carry    = c_q;
  assign overflow = v_q;
  assign done     = done_q;
`ifdef ALU_SEQ_MUL_EN
  assign busy = (state_q == ST_MUL);
`else
  assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq (WIDTH=16), either ALU_SEQ_MUL_EN setting.
module tb_alu_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [15:0] a, b, y;
  logic [3:0]  op_alu;
  logic        zero, negative, carry, overflow, busy, done;

  typedef struct {
    logic [15:0] y;
    logic        z, n, c, v;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  alu_seq #(.WIDTH(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .op_alu   (op_alu),
    .y        (y),
    .zero     (zero),
    .negative (negative),
    .carry    (carry),
    .overflow (overflow),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic do_op(input logic [3:0] op, input logic [15:0] av, input logic [15:0] bv);
    op_alu = op;
    a      = av;
    b      = bv;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
  endtask

  task automatic push(input logic [15:0] ey, input logic ez, input logic en,
                      input logic ec, input logic ev, input string name);
    exp_t e;
    e.y = ey; e.z = ez; e.n = en; e.c = ec; e.v = ev; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic exp_op(input logic [3:0] op, input logic [15:0] av, input logic [15:0] bv,
                        input logic [15:0] ey, input logic ez, input logic en,
                        input logic ec, input logic ev, input string name);
    push(ey, ez, en, ec, ev, name);
    do_op(op, av, bv);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'(y), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk({e.name, ".y"}, 32'(y),        32'(e.y));
          chk({e.name, ".z"}, 32'(zero),     32'(e.z));
          chk({e.name, ".n"}, 32'(negative), 32'(e.n));
          chk({e.name, ".c"}, 32'(carry),    32'(e.c));
          chk({e.name, ".v"}, 32'(overflow), 32'(e.v));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int busy_cnt;
    int done_at;
    reset = 1'b1; start = 1'b0; a = '0; b = '0; op_alu = OP_MOV;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst.y", 32'(y), 32'h0);
    chk("rst.zero", 32'(zero), 32'h1);
    chk("rst.nvc", 32'({negative, carry, overflow}), 32'h0);
    chk("rst.busy", 32'(busy), 32'h0);
    chk("rst.done", 32'(done), 32'h0);

`ifdef ALU_SEQ_MUL_EN
    // Reset during a multiply: no partial result, no done pulse afterwards.
    do_op(OP_MUL, 16'h0003, 16'h0005);
    repeat (4) @(negedge clk);
    chk("midmul.busy_before", 32'(busy), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    chk("midmul_rst.y", 32'(y), 32'h0);
    chk("midmul_rst.zero", 32'(zero), 32'h1);
    chk("midmul_rst.busy", 32'(busy), 32'h0);
    chk("midmul_rst.done", 32'(done), 32'h0);
    reset = 1'b0;
    repeat (24) @(negedge clk);
    chk("midmul.busy_after", 32'(busy), 32'h0);
`endif

    // Single-cycle latency: done and result one cycle after the accepting edge.
    exp_op(OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1, 0, 1, 0, "add_wrap");
    @(negedge clk);
    chk("add.done_latency", 32'(done), 32'h1);
    chk("add.busy", 32'(busy), 32'h0);

    // Back-to-back stream; ADC consumes the carry from the previous ADD.
    exp_op(OP_ADC, 16'h0001, 16'h0001, 16'h0003, 0, 0, 0, 0, "adc");
    exp_op(OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 0, 0, 0, 1, "sub_ovf");
    exp_op(OP_CMP, 16'h0003, 16'h0005, 16'h7FFF, 0, 1, 1, 0, "cmp");
    exp_op(OP_ASR, 16'h8004, 16'h0002, 16'hE001, 0, 1, 0, 0, "asr");
    exp_op(OP_LSL, 16'hC000, 16'h0001, 16'h8000, 0, 1, 1, 0, "lsl");
    exp_op(OP_LSR, 16'h00F1, 16'h0000, 16'h00F1, 0, 0, 0, 0, "lsr_zero_amt");
    exp_op(OP_LSR, 16'h0003, 16'h0001, 16'h0001, 0, 0, 1, 0, "lsr");
    exp_op(OP_XOR, 16'hF0F0, 16'hFF00, 16'h0FF0, 0, 0, 0, 0, "xor");
    exp_op(OP_NGA, 16'h0001, 16'h1234, 16'hFFFF, 0, 1, 1, 0, "neg_a");
    exp_op(OP_NGB, 16'h1234, 16'h8000, 16'h8000, 0, 1, 1, 1, "neg_b_min");
    exp_op(OP_RSV, 16'h1234, 16'h5678, 16'h0000, 1, 0, 0, 0, "reserved");
    exp_op(OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 0, 1, 0, 1, "add_ovf");
    exp_op(OP_AND, 16'h0FF0, 16'h00FF, 16'h00F0, 0, 0, 0, 0, "and");
    exp_op(OP_OR,  16'h0F00, 16'h00F0, 16'h0FF0, 0, 0, 0, 0, "or");
    exp_op(OP_NOT, 16'h00FF, 16'h0000, 16'hFF00, 0, 1, 0, 0, "not");
    exp_op(OP_LSL, 16'h0001, 16'h0011, 16'h0002, 0, 0, 0, 0, "lsl_amt_mask");
    exp_op(OP_MOV, 16'h1234, 16'hFFFF, 16'h1234, 0, 0, 0, 0, "mov");

    repeat (3) @(negedge clk);
    chk("idle.done", 32'(done), 32'h0);
    chk("idle.y_hold", 32'(y), 32'h1234);

`ifdef ALU_SEQ_MUL_EN
    push(16'h0000, 1, 0, 1, 1, "mul");
    do_op(OP_MUL, 16'h0100, 16'h0100);
    busy_cnt = 0;
    done_at  = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      if (i == 8) chk("mul.y_hold", 32'(y), 32'h1234);
      if (done === 1'b1) begin
        done_at = i;
        break;
      end
      if (i == 3) begin
        op_alu = OP_ADD; a = 16'h0001; b = 16'h0001; start = 1'b1;
      end
      if (i == 4) start = 1'b0;
    end
    start = 1'b0;
    chk("mul.busy_cycles", 32'(busy_cnt), 32'd16);
    chk("mul.done_cycle", 32'(done_at), 32'd17);
    chk("mul.busy_at_done", 32'(busy), 32'h0);
`else
    push(16'h0000, 1, 0, 0, 0, "mul_disabled");
    do_op(OP_MUL, 16'h0100, 16'h0100);
    @(negedge clk);
    chk("mul_dis.done", 32'(done), 32'h1);
    chk("mul_dis.busy", 32'(busy), 32'h0);
    @(negedge clk);
    chk("mul_dis.busy_later", 32'(busy), 32'h0);
`endif

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
